// File: rtl/lock_input_debounce_if.sv
// Signal bundle between the raw lock front panel (switches, buttons) and the
// conditioning block: raw inputs in, debounced levels, press pulses and key snapshot out.
interface lock_input_debounce_if;
  logic       Key1;
  logic       Key2;
  logic       Key3;
  logic       Key4;
  logic       Button1;
  logic       Button2;
  logic [3:0] Key_Db;
  logic       Button1_Db;
  logic       Button2_Db;
  logic       Press1;
  logic       Press2;
  logic [3:0] Key_Snap;

  modport master (
    output Key1, Key2, Key3, Key4, Button1, Button2,
    input  Key_Db, Button1_Db, Button2_Db, Press1, Press2, Key_Snap
  );

  modport slave (
    input  Key1, Key2, Key3, Key4, Button1, Button2,
    output Key_Db, Button1_Db, Button2_Db, Press1, Press2, Key_Snap
  );
endinterface

// File: rtl/lock_input_debounce.sv
// Input conditioning for the combination lock: synchronizes and debounces the two
// active-low buttons, emits one pulse per press and snapshots the switch vector.
// Define KEY_DEBOUNCE_EN to debounce the four switches as well (else sync only).
module lock_input_debounce #(
  parameter int DEB_CNT = 50000
) (
  input logic                  Clk,
  input logic                  Rst,
  lock_input_debounce_if.slave bus
);

`ifdef KEY_DEBOUNCE_EN
  localparam int NCH = 6;
  localparam logic [NCH-1:0] CH_RST = 6'b000011;
`else
  localparam int NCH = 2;
  localparam logic [NCH-1:0] CH_RST = 2'b11;
`endif

  localparam logic [15:0] CNT_MAX = 16'(DEB_CNT - 1);

  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 16'd1;
  endfunction

  logic [3:0]     key_raw;
  logic [1:0]     btn_raw;
  logic [3:0]     key_p0, key_p1;
  logic [1:0]     btn_p0, btn_p1;
  logic [NCH-1:0] ch_sync;
  logic [NCH-1:0] ch_db, ch_db_nxt, ch_fire;
  logic [15:0]    ch_cnt     [NCH];
  logic [15:0]    ch_cnt_nxt [NCH];
  logic [1:0]     press_nxt, press_q;
  logic [3:0]     key_db, key_snap;

  assign key_raw = {bus.Key1, bus.Key2, bus.Key3, bus.Key4};
  assign btn_raw = {bus.Button2, bus.Button1};

  // Stage p0/p1: two-flop synchronizers; buttons idle high, switches idle low
  always_ff @(posedge Clk) begin
    if (Rst) begin
      key_p0 <= 4'b0000;
      key_p1 <= 4'b0000;
      btn_p0 <= 2'b11;
      btn_p1 <= 2'b11;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  assign ch_sync = {key_p1, btn_p1};
  assign key_db  = ch_db[5:2];
`else
  assign ch_sync = btn_p1;
  assign key_db  = key_p1;
`endif

  // Debounce: level flips after DEB_CNT consecutive differing samples
  always_comb begin
    ch_db_nxt = ch_db;
    ch_fire   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_cnt_nxt[i] = 16'd0;
      if (ch_sync[i] != ch_db[i]) begin
        if (ch_cnt[i] >= CNT_MAX) begin
          ch_fire[i]   = 1'b1;
          ch_db_nxt[i] = ch_sync[i];
        end else begin
          ch_cnt_nxt[i] = cnt_sat_inc(ch_cnt[i]);
        end
      end
    end
    // Only a 1->0 flip of an active-low button counts as a press
    press_nxt = ch_fire[1:0] & ch_db[1:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ch_db    <= CH_RST;
      press_q  <= 2'b00;
      key_snap <= 4'b0000;
      for (int i = 0; i < NCH; i++) ch_cnt[i] <= 16'd0;
    end else begin
      ch_db   <= ch_db_nxt;
      press_q <= press_nxt;
      for (int i = 0; i < NCH; i++) ch_cnt[i] <= ch_cnt_nxt[i];
      if (|press_nxt) key_snap <= key_db;
    end
  end

  assign bus.Key_Db     = key_db;
  assign bus.Button1_Db = ch_db[0];
  assign bus.Button2_Db = ch_db[1];
  assign bus.Press1     = press_q[0];
  assign bus.Press2     = press_q[1];
  assign bus.Key_Snap   = key_snap;

endmodule

// File: tb/tb_lock_input_debounce.sv
// Randomized and directed bench for lock_input_debounce with a windowed reference
// model: a level flips once DEB synchronized samples in a row differ from it.
module tb_lock_input_debounce;
  localparam int DEB = 4;
  localparam int MAXC = 4096;
  localparam logic [5:0] RSTV = 6'b000011;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  lock_input_debounce_if bus();
  lock_input_debounce #(.DEB_CNT(DEB)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rst = -100;
  int ph = 0;
  int p1_cnt = 0, p2_cnt = 0, pboth = 0, p1_at = -1, kb1_cnt = 0;

  logic [5:0] raw_ch [0:MAXC-1];
  logic [5:0] db_m;
  logic [1:0] press_m;
  logic [3:0] keydb_m, snap_m;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Synchronized value of channel ch as seen by the logic at edge m
  function automatic logic seen(input int ch, input int m);
    if (m - 2 <= last_rst || m - 2 < 0) return RSTV[ch];
    return raw_ch[m-2][ch];
  endfunction

  task automatic model_edge(input logic r);
    logic [5:0] old_db, new_db;
    logic [3:0] old_kdb;
    logic flip;
    if (r) begin
      db_m = RSTV; press_m = 2'b00; keydb_m = 4'b0000; snap_m = 4'b0000;
      last_rst = cyc;
      return;
    end
    old_db = db_m; old_kdb = keydb_m; new_db = db_m;
    for (int ch = 0; ch < 6; ch++) begin
      flip = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        if (cyc - k <= last_rst || seen(ch, cyc - k) == old_db[ch]) flip = 1'b0;
      end
      if (flip) new_db[ch] = ~old_db[ch];
    end
    press_m = old_db[1:0] & ~new_db[1:0];
    if (|press_m) snap_m = old_kdb;
    db_m = new_db;
`ifdef KEY_DEBOUNCE_EN
    keydb_m = db_m[5:2];
`else
    keydb_m = (cyc - 1 <= last_rst) ? 4'b0000 : raw_ch[cyc-1][5:2];
`endif
  endtask

  task automatic step(input logic r, input logic [1:0] b, input logic [3:0] k);
    Rst = r;
    bus.Button1 = b[0];
    bus.Button2 = b[1];
    {bus.Key1, bus.Key2, bus.Key3, bus.Key4} = k;
    @(posedge Clk);
    raw_ch[cyc] = {k, b};
    model_edge(r);
    ph++;
    #1;
    check("button1_db", 32'(bus.Button1_Db), 32'(db_m[0]));
    check("button2_db", 32'(bus.Button2_Db), 32'(db_m[1]));
    check("press1",     32'(bus.Press1),     32'(press_m[0]));
    check("press2",     32'(bus.Press2),     32'(press_m[1]));
    check("key_db",     32'(bus.Key_Db),     32'(keydb_m));
    check("key_snap",   32'(bus.Key_Snap),   32'(snap_m));
    if (bus.Press1) begin p1_cnt++; p1_at = ph; end
    if (bus.Press2) p2_cnt++;
    if (bus.Press1 && bus.Press2) pboth++;
    if (bus.Key_Db[1]) kb1_cnt++;
    cyc++;
  endtask

  task automatic clr();
    ph = 0; p1_cnt = 0; p2_cnt = 0; pboth = 0; p1_at = -1; kb1_cnt = 0;
  endtask

  initial begin
    logic [1:0] b;
    logic [3:0] k;
    logic r;
    int idx;

    // Reset held three cycles
    repeat (3) step(1'b1, 2'b11, 4'b0000);
    check("rst_button1_db", 32'(bus.Button1_Db), 1);
    check("rst_button2_db", 32'(bus.Button2_Db), 1);
    check("rst_press",      32'({bus.Press2, bus.Press1}), 0);
    check("rst_key_db",     32'(bus.Key_Db), 0);
    check("rst_key_snap",   32'(bus.Key_Snap), 0);

    // Button1 held low: one pulse 6 cycles in, none on release
    clr();
    repeat (12) step(1'b0, 2'b10, 4'b0000);
    check("hold_press1_count", p1_cnt, 1);
    check("hold_press1_latency", p1_at, 6);
    clr();
    repeat (8) step(1'b0, 2'b11, 4'b0000);
    check("release_press1_count", p1_cnt, 0);
    check("release_button1_db", 32'(bus.Button1_Db), 1);

    // Button2 glitch of 3 cycles
    clr();
    repeat (3) step(1'b0, 2'b01, 4'b0000);
    repeat (8) step(1'b0, 2'b11, 4'b0000);
    check("glitch_press2_count", p2_cnt, 0);
    check("glitch_button2_db", 32'(bus.Button2_Db), 1);

    // Simultaneous press with keys 1010, then keys change with no press
    repeat (8) step(1'b0, 2'b11, 4'b1010);
    clr();
    repeat (10) step(1'b0, 2'b00, 4'b1010);
    check("both_same_cycle", pboth, 1);
    check("both_press1_count", p1_cnt, 1);
    check("both_press2_count", p2_cnt, 1);
    check("snap_1010", 32'(bus.Key_Snap), 32'(4'b1010));
    repeat (10) step(1'b0, 2'b00, 4'b0101);
    check("snap_hold_1010", 32'(bus.Key_Snap), 32'(4'b1010));
    repeat (8) step(1'b0, 2'b11, 4'b0101);

    // Reset in the middle of a debounce
    clr();
    repeat (3) step(1'b0, 2'b10, 4'b0000);
    check("pre_rst_press1_count", p1_cnt, 0);
    step(1'b1, 2'b10, 4'b0000);
    clr();
    repeat (10) step(1'b0, 2'b10, 4'b0000);
    check("post_rst_press1_count", p1_cnt, 1);
    check("post_rst_press1_latency", p1_at, 6);
    repeat (8) step(1'b0, 2'b11, 4'b0000);

    // Key3 toggled for 2 cycles
    clr();
    repeat (2) step(1'b0, 2'b11, 4'b0010);
    repeat (6) step(1'b0, 2'b11, 4'b0000);
`ifdef KEY_DEBOUNCE_EN
    check("key3_toggle_cycles", kb1_cnt, 0);
`else
    check("key3_toggle_cycles", kb1_cnt, 2);
`endif

    // Randomized traffic with occasional resets
    b = 2'b11;
    k = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) b[0] = ~b[0];
      if ($urandom_range(0, 5) == 0) b[1] = ~b[1];
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        k[idx] = ~k[idx];
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, b, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
